conv_3x3_channel_seq: RTL
=========================

CONV_3X3_CHANNEL_SEQ -- requirements
Module: conv_3x3_channel_seq

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly the following.
- DATA_WIDTH, 32, pixel/weight word width.
- IMAGE_WIDTH, 16, columns per channel.
- IMAGE_HEIGHT, 16, rows per channel.
- CHANNEL_NUM_IN, 512, input channels per job.
- KERNEL_SIZE, 9, weights per channel.
- OUT_SIZE, 256, datapath results expected per channel.
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly the following; clk is the only clock, and reset is asynchronous and active-low.
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, job request pulse.
- w_valid, in, 1, upstream weight word valid.
- w_data, in, DATA_WIDTH, upstream weight word.
- w_ready, out, 1, weight accept.
- p_valid, in, 1, upstream pixel valid.
- p_data, in, DATA_WIDTH, upstream pixel.
- p_ready, out, 1, pixel accept.
- valid_weight_out, out, 1, weight beat to datapath.
- weight_out, out, DATA_WIDTH, weight to datapath.
- valid_pxl_out, out, 1, pixel beat to datapath.
- pxl_out, out, DATA_WIDTH, pixel to datapath.
- conv_valid, in, 1, datapath result strobe.
- chan_idx, out, clog2(CHANNEL_NUM_IN), current channel.
- busy, out, 1, job active.
- done, out, 1, one-cycle job-complete pulse.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-004 In IDLE, start=1 SHALL move the FSM to LOAD_W on the next edge; start SHALL be ignored in every other state.
REQ-005 w_ready SHALL be 1 only in LOAD_W; a weight transfer is w_valid&w_ready.
REQ-006 After the KERNEL_SIZE-th weight transfer, the FSM SHALL move to STREAM, with no further w_ready in the same cycle.
REQ-007 p_ready SHALL be 1 only in STREAM; a pixel transfer is p_valid&p_ready.
REQ-008 After the IMAGE_WIDTH*IMAGE_HEIGHT-th pixel transfer, the FSM SHALL move to DRAIN.
REQ-009 Each transfer SHALL be registered to the datapath with 1-cycle latency: valid_*_out=1 and data equal to the accepted word, otherwise valid_*_out=0 and data held.
REQ-010 A result counter SHALL count conv_valid pulses in STREAM and DRAIN, and clear on entry to LOAD_W.
REQ-011 In DRAIN, the FSM SHALL leave the state when the count reaches OUT_SIZE, including a conv_valid pulse in the current cycle.
- If chan_idx=CHANNEL_NUM_IN-1, the next state SHALL be DONE.
- Otherwise, chan_idx SHALL increment and the next state SHALL be LOAD_W.
REQ-012 If the count reaches OUT_SIZE while in STREAM, completion SHALL take effect on the first DRAIN cycle; results SHALL never be lost.
REQ-013 conv_valid in IDLE or LOAD_W SHALL be ignored.
REQ-014 DONE SHALL last one cycle with done=1, then return to IDLE with chan_idx=0.
REQ-015 busy SHALL be 1 in LOAD_W, STREAM and DRAIN, and 0 in IDLE and DONE.
REQ-016 Counters SHALL be sized clog2(max+1) and never wrap within a job.

Reset
REQ-017 reset=0 SHALL asynchronously force the following state at any point, including mid-job:
- state=IDLE.
- all counters 0 and chan_idx=0.
- w_ready, p_ready, valid_weight_out, valid_pxl_out, busy and done all 0.
- weight_out and pxl_out 0.
REQ-018 Reset release SHALL take effect at the first clk edge after the deassertion; no transfer SHALL be accepted in the release cycle.

Configuration
REQ-019 With CONV_SEQ_PERF_CNT_EN defined, the block SHALL add output cycle_cnt [31:0].
- cycle_cnt SHALL clear on start acceptance.
- cycle_cnt SHALL increment every busy cycle and saturate at 0xFFFFFFFF.
- cycle_cnt SHALL hold its value after done.
REQ-020 Without CONV_SEQ_PERF_CNT_EN, the cycle_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-021 The state enumeration and the clog2 width helper SHALL reside in the shared conv_3x3 parameter include/package, alongside the DATA_WIDTH definition.
REQ-022 Pixel and weight output registers SHALL be one sub-module, conv_seq_out_reg, instantiated twice.
REQ-023 The FSM and counters SHALL stay in the top module.

Verification
REQ-024 A bench SHALL cover at least these directed scenarios.
- Nominal: set CHANNEL_NUM_IN=2, IMAGE 4x4, OUT_SIZE=4; one start, continuous valids, conv_valid 4 times per channel. Expected: 9 weight beats, then 16 pixel beats per channel; chan_idx goes 0 to 1; done pulses exactly once; busy drops with done.
- Backpressure: toggle w_valid/p_valid every other cycle. Expected: exactly 9 and 16 accepted beats per channel; valid_*_out follows each accept by 1 cycle with matching data.
- Early results: 4 conv_valid pulses during STREAM. Expected: STREAM to DRAIN, then the next channel's LOAD_W one cycle later, with no extra wait.
- Ignored start: start pulse while busy. Expected: no restart and chan_idx unchanged. A conv_valid in IDLE is also ignored.
- Mid-job reset: reset=0 in STREAM after the 7th pixel. Expected: all outputs 0 immediately; a new job starts cleanly from channel 0.
- Performance counter: run with CONV_SEQ_PERF_CNT_EN defined on the nominal job. Expected: cycle_cnt at done equals the number of busy cycles counted by the bench.

Source files
------------

// File: rtl/conv_3x3_channel_seq_pkg.sv
// Shared definitions for the conv_3x3 channel sequencer: the default word
// width, the sequencer state encoding and the counter width helper.
package conv_3x3_channel_seq_pkg;

   localparam int unsigned DATA_WIDTH_DFLT = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } seq_state_e;

   // clog2 with a floor of one bit so degenerate parameters still give a legal vector
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/conv_3x3_channel_seq_if.sv
// Handshake bundle between the upstream feeders, the channel sequencer and
// the convolution datapath. cycle_cnt exists only when CONV_SEQ_PERF_CNT_EN
// is defined.
interface conv_3x3_channel_seq_if #(
   parameter int unsigned DATA_WIDTH     = conv_3x3_channel_seq_pkg::DATA_WIDTH_DFLT,
   parameter int unsigned CHANNEL_NUM_IN = 512
);
   import conv_3x3_channel_seq_pkg::*;

   localparam int unsigned CHAN_W = cnt_w(CHANNEL_NUM_IN);

   logic                  start;
   logic                  w_valid;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_ready;
   logic                  p_valid;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  p_ready;
   logic                  valid_weight_out;
   logic [DATA_WIDTH-1:0] weight_out;
   logic                  valid_pxl_out;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  conv_valid;
   logic [CHAN_W-1:0]     chan_idx;
   logic                  busy;
   logic                  done;
`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0]           cycle_cnt;
`endif

   // sequencer side
   modport slave (
      input  start, w_valid, w_data, p_valid, p_data, conv_valid,
      output w_ready, p_ready, valid_weight_out, weight_out, valid_pxl_out, pxl_out,
             chan_idx, busy, done
`ifdef CONV_SEQ_PERF_CNT_EN
      , output cycle_cnt
`endif
   );

   // feeder / datapath side
   modport master (
      output start, w_valid, w_data, p_valid, p_data, conv_valid,
      input  w_ready, p_ready, valid_weight_out, weight_out, valid_pxl_out, pxl_out,
             chan_idx, busy, done
`ifdef CONV_SEQ_PERF_CNT_EN
      , input cycle_cnt
`endif
   );

endinterface

// File: rtl/conv_seq_out_reg.sv
// One-cycle output stage toward the datapath: the valid flag follows the
// accept strobe, the data word is captured on accept and held otherwise.
module conv_seq_out_reg
   import conv_3x3_channel_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   // register the accepted beat; data holds between beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= load_i;
         if (load_i) begin
            data_q <= data_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/conv_3x3_channel_seq.sv
// Per-channel sequencer for a 3x3 convolution job: loads one kernel, streams
// one image plane, waits for the datapath results, then moves to the next
// input channel. Optional cycle counter behind CONV_SEQ_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | accepting KERNEL_SIZE weights for chan_idx
// STREAM | accepting IMAGE_WIDTH*IMAGE_HEIGHT pixels
// DRAIN  | waiting until OUT_SIZE results have been seen
// DONE   | one-cycle job-complete pulse
module conv_3x3_channel_seq
   import conv_3x3_channel_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DFLT,
   parameter int unsigned IMAGE_WIDTH    = 16,
   parameter int unsigned IMAGE_HEIGHT   = 16,
   parameter int unsigned CHANNEL_NUM_IN = 512,
   parameter int unsigned KERNEL_SIZE    = 9,
   parameter int unsigned OUT_SIZE       = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   conv_3x3_channel_seq_if.slave bus
);

   localparam int unsigned PIX_NUM = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int unsigned W_CW    = cnt_w(KERNEL_SIZE + 1);
   localparam int unsigned P_CW    = cnt_w(PIX_NUM + 1);
   localparam int unsigned R_CW    = cnt_w(OUT_SIZE + 1);
   localparam int unsigned CH_W    = cnt_w(CHANNEL_NUM_IN);

   localparam logic [W_CW-1:0] W_LAST  = W_CW'(KERNEL_SIZE - 1);
   localparam logic [P_CW-1:0] P_LAST  = P_CW'(PIX_NUM - 1);
   localparam logic [R_CW-1:0] R_FULL  = R_CW'(OUT_SIZE);
   localparam logic [R_CW-1:0] R_LAST  = R_CW'(OUT_SIZE - 1);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL_NUM_IN - 1);

   seq_state_e      state_q, state_d;
   logic [W_CW-1:0] w_cnt_q, w_cnt_d;
   logic [P_CW-1:0] p_cnt_q, p_cnt_d;
   logic [R_CW-1:0] r_cnt_q, r_cnt_d;
   logic [CH_W-1:0] chan_q, chan_d;

   logic w_xfer;
   logic p_xfer;
   logic res_phase;
   logic r_inc;
   logic res_hit;
   logic busy_w;

   assign w_xfer    = bus.w_valid && (state_q == LOAD_W);
   assign p_xfer    = bus.p_valid && (state_q == STREAM);
   assign res_phase = (state_q == STREAM) || (state_q == DRAIN);
   // results saturate at OUT_SIZE so a burst arriving during STREAM is never lost or wrapped
   assign r_inc     = bus.conv_valid && res_phase && (r_cnt_q != R_FULL);
   assign res_hit   = (r_cnt_q == R_FULL) || (bus.conv_valid && (r_cnt_q == R_LAST));
   assign busy_w    = res_phase || (state_q == LOAD_W);

   // next-state and counter update
   always_comb begin
      state_d = state_q;
      w_cnt_d = w_cnt_q;
      p_cnt_d = p_cnt_q;
      r_cnt_d = r_inc ? r_cnt_q + 1'b1 : r_cnt_q;
      chan_d  = chan_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD_W;
               w_cnt_d = '0;
               r_cnt_d = '0;
            end
         end
         LOAD_W: begin
            if (w_xfer) begin
               if (w_cnt_q == W_LAST) begin
                  state_d = STREAM;
                  w_cnt_d = '0;
                  p_cnt_d = '0;
               end else begin
                  w_cnt_d = w_cnt_q + 1'b1;
               end
            end
         end
         STREAM: begin
            if (p_xfer) begin
               if (p_cnt_q == P_LAST) begin
                  state_d = DRAIN;
                  p_cnt_d = '0;
               end else begin
                  p_cnt_d = p_cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (res_hit) begin
               if (chan_q == CH_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD_W;
                  chan_d  = chan_q + 1'b1;
                  w_cnt_d = '0;
                  r_cnt_d = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            chan_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         w_cnt_q <= '0;
         p_cnt_q <= '0;
         r_cnt_q <= '0;
         chan_q  <= '0;
      end else begin
         state_q <= state_d;
         w_cnt_q <= w_cnt_d;
         p_cnt_q <= p_cnt_d;
         r_cnt_q <= r_cnt_d;
         chan_q  <= chan_d;
      end
   end

   assign bus.w_ready  = (state_q == LOAD_W);
   assign bus.p_ready  = (state_q == STREAM);
   assign bus.busy     = busy_w;
   assign bus.done     = (state_q == DONE);
   assign bus.chan_idx = chan_q;

   conv_seq_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_weight_reg (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (w_xfer),
      .data_i  (bus.w_data),
      .valid_o (bus.valid_weight_out),
      .data_o  (bus.weight_out)
   );

   conv_seq_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_pxl_reg (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (p_xfer),
      .data_i  (bus.p_data),
      .valid_o (bus.valid_pxl_out),
      .data_o  (bus.pxl_out)
   );

`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0] cyc_q, cyc_d;

   // job cycle counter: cleared when start is taken, saturating, frozen outside busy
   always_comb begin
      cyc_d = cyc_q;
      if ((state_q == IDLE) && bus.start) begin
         cyc_d = '0;
      end else if (busy_w && (cyc_q != 32'hFFFF_FFFF)) begin
         cyc_d = cyc_q + 32'd1;
      end
   end

   // cycle counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign bus.cycle_cnt = cyc_q;
`endif

endmodule
